// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap controller: FSM state encoding, cause width and core PC width.
package trap_ctrl_pkg;

  localparam int CAUSE_W   = 4;
  localparam int CORE_PC_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BND = 2'd1,
    ST_HANDLER  = 2'd2,
    ST_GUARD    = 2'd3
  } state_e;

endpackage

// File: rtl/trap_ctrl_irq_prio_enc.sv
// Lowest-index-first priority encoder: index 0 has the highest priority.
module irq_prio_enc
  import trap_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic [CAUSE_W-1:0] o_idx,
  output logic               o_vld
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = CAUSE_W'(i);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap initiator: latches irq rising edges, arbitrates them, and issues trap entry/exit
// pulses plus fetch redirects at instruction commit boundaries.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int PC_W    = CORE_PC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               int_mstatus_mie,
  input  logic [PC_W-1:0]    trap_entry_pc,
  input  logic [PC_W-1:0]    restore_pc,
  input  logic               commit_valid,
  input  logic [PC_W-1:0]    commit_next_pc,
  input  logic               mret_commit,
  output logic               trap_entry_en,
  output logic               trap_exit_en,
  output logic [CAUSE_W-1:0] int_index,
  output logic [PC_W-1:0]    normal_pc,
  output logic               redirect_en,
  output logic [PC_W-1:0]    redirect_pc,
  output logic [NUM_IRQ-1:0] irq_pending
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [NUM_IRQ-1:0]   r_irq_q;
  logic [NUM_IRQ-1:0]   r_pending;
  logic [NUM_IRQ-1:0]   w_rise;
  logic [NUM_IRQ-1:0]   w_clr;
  logic [CAUSE_W-1:0]   w_sel;
  logic                 w_sel_vld;
  logic                 w_mret;
  logic                 w_plain_commit;
  logic                 w_take_entry;
  logic                 w_take_exit;

  logic                 r_entry_en;
  logic                 r_exit_en;
  logic                 r_redirect_en;
  logic [CAUSE_W-1:0]   r_int_index;
  logic [PC_W-1:0]      r_normal_pc;
  logic [PC_W-1:0]      r_redirect_pc;

  assign w_rise         = irq & ~r_irq_q;
  assign w_mret         = commit_valid & mret_commit;
  assign w_plain_commit = commit_valid & ~mret_commit;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .i_req (r_pending),
    .o_idx (w_sel),
    .o_vld (w_sel_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_mret)                                 w_state_nxt = ST_GUARD;
        else if (|r_pending && int_mstatus_mie)     w_state_nxt = ST_WAIT_BND;
      end
      ST_WAIT_BND: begin
        if (!int_mstatus_mie)                       w_state_nxt = ST_IDLE;
        else if (w_mret)                            w_state_nxt = ST_GUARD;
        else if (w_plain_commit && w_sel_vld)       w_state_nxt = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (w_mret)                                 w_state_nxt = ST_GUARD;
      end
      ST_GUARD:                                     w_state_nxt = ST_IDLE;
      default:                                      w_state_nxt = ST_IDLE;
    endcase
  end

  // Exit wins over entry in WAIT_BND; an mret with no trap taken still returns.
  always_comb begin
    w_take_entry = 1'b0;
    w_take_exit  = 1'b0;
    case (r_state)
      ST_IDLE:     w_take_exit  = w_mret;
      ST_WAIT_BND: begin
        w_take_exit  = int_mstatus_mie & w_mret;
        w_take_entry = int_mstatus_mie & w_plain_commit & w_sel_vld;
      end
      ST_HANDLER:  w_take_exit  = w_mret;
      default:     ;
    endcase
  end

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_clr[i] = w_take_entry && (w_sel == CAUSE_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_q   <= '0;
      r_pending <= '0;
    end else begin
      r_irq_q   <= irq;
      r_pending <= (r_pending & ~w_clr) | w_rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry_en    <= 1'b0;
      r_exit_en     <= 1'b0;
      r_redirect_en <= 1'b0;
      r_int_index   <= '0;
      r_normal_pc   <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_entry_en    <= w_take_entry;
      r_exit_en     <= w_take_exit;
      r_redirect_en <= w_take_entry | w_take_exit;
      r_int_index   <= w_take_entry ? w_sel : '0;
      r_normal_pc   <= w_take_entry ? commit_next_pc : '0;
      r_redirect_pc <= w_take_entry ? trap_entry_pc :
                       w_take_exit  ? restore_pc    : '0;
    end
  end

  assign trap_entry_en = r_entry_en;
  assign trap_exit_en  = r_exit_en;
  assign redirect_en   = r_redirect_en;
  assign int_index     = r_int_index;
  assign normal_pc     = r_normal_pc;
  assign redirect_pc   = r_redirect_pc;
  assign irq_pending   = r_pending;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus queues expected entry/exit events, a negedge monitor checks them.
module tb_trap_ctrl;

  localparam int NUM_IRQ = 8;
  localparam int PC_W    = 32;
  localparam logic [31:0] MTVEC = 32'h0000_8000;
  localparam logic [31:0] MEPC  = 32'h0000_4444;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_IRQ-1:0] irq;
  logic               int_mstatus_mie;
  logic [PC_W-1:0]    trap_entry_pc;
  logic [PC_W-1:0]    restore_pc;
  logic               commit_valid;
  logic [PC_W-1:0]    commit_next_pc;
  logic               mret_commit;
  logic               trap_entry_en;
  logic               trap_exit_en;
  logic [3:0]         int_index;
  logic [PC_W-1:0]    normal_pc;
  logic               redirect_en;
  logic [PC_W-1:0]    redirect_pc;
  logic [NUM_IRQ-1:0] irq_pending;

  trap_ctrl #(.NUM_IRQ(NUM_IRQ), .PC_W(PC_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .irq             (irq),
    .int_mstatus_mie (int_mstatus_mie),
    .trap_entry_pc   (trap_entry_pc),
    .restore_pc      (restore_pc),
    .commit_valid    (commit_valid),
    .commit_next_pc  (commit_next_pc),
    .mret_commit     (mret_commit),
    .trap_entry_en   (trap_entry_en),
    .trap_exit_en    (trap_exit_en),
    .int_index       (int_index),
    .normal_pc       (normal_pc),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc),
    .irq_pending     (irq_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_exit;
    logic [3:0]  idx;
    logic [31:0] npc;
    logic [31:0] rpc;
    int          cyc;
  } ev_t;

  ev_t q[$];
  int  n_checks = 0;
  int  n_err    = 0;
  int  cyc_cnt  = 0;

  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic commit_entry(input logic [3:0] idx, input logic [31:0] npc);
    ev_t e;
    e.is_exit = 1'b0; e.idx = idx; e.npc = npc; e.rpc = MTVEC; e.cyc = cyc_cnt + 1;
    q.push_back(e);
    commit_valid   = 1'b1;
    mret_commit    = 1'b0;
    commit_next_pc = npc;
    step(1);
    commit_valid   = 1'b0;
  endtask

  task automatic commit_mret();
    ev_t e;
    e.is_exit = 1'b1; e.idx = '0; e.npc = '0; e.rpc = MEPC; e.cyc = cyc_cnt + 1;
    q.push_back(e);
    commit_valid = 1'b1;
    mret_commit  = 1'b1;
    step(1);
    commit_valid = 1'b0;
    mret_commit  = 1'b0;
  endtask

  // Monitor: every pulse must match the oldest queued expectation, on the expected cycle.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      chk("redirect_en_vs_pulse", {63'd0, redirect_en}, {63'd0, trap_entry_en | trap_exit_en});
      chk("entry_exit_exclusive", {63'd0, trap_entry_en & trap_exit_en}, 64'd0);
      if (trap_entry_en || trap_exit_en) begin
        if (q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_pulse: got entry=%0b exit=%0b expected none (cycle %0d)",
                   trap_entry_en, trap_exit_en, cyc_cnt);
        end else begin
          e = q.pop_front();
          chk("pulse_cycle", 64'(cyc_cnt), 64'(e.cyc));
          chk("exit_en", {63'd0, trap_exit_en}, {63'd0, e.is_exit});
          chk("entry_en", {63'd0, trap_entry_en}, {63'd0, !e.is_exit});
          chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, e.rpc});
          if (!e.is_exit) begin
            chk("int_index", {60'd0, int_index}, {60'd0, e.idx});
            chk("normal_pc", {32'd0, normal_pc}, {32'd0, e.npc});
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; irq = '0; int_mstatus_mie = 1'b1;
    trap_entry_pc = MTVEC; restore_pc = MEPC;
    commit_valid = 1'b0; commit_next_pc = '0; mret_commit = 1'b0;
    step(2);
    chk("rst_entry_en", {63'd0, trap_entry_en}, 64'd0);
    chk("rst_redirect_en", {63'd0, redirect_en}, 64'd0);
    chk("rst_pending", {56'd0, irq_pending}, 64'd0);
    rst_n = 1'b1;
    step(1);

    // mret with no trap taken still exits
    commit_mret();
    step(1);

    // single irq[3] pulse
    irq = 8'h08; step(1); irq = '0;
    chk("pend_after_edge3", {56'd0, irq_pending}, 64'h08);
    step(1);
    commit_entry(4'd3, 32'h100);
    chk("pend3_cleared", {56'd0, irq_pending}, 64'h00);
    commit_mret();
    step(1);

    // simultaneous irq[5] and irq[2]; 2 wins, 5 stays pending
    irq = 8'h24; step(1); irq = '0; step(1);
    commit_entry(4'd2, 32'h200);
    chk("pend5_kept", {56'd0, irq_pending}, 64'h20);
    commit_mret();
    step(2);
    commit_entry(4'd5, 32'h204);
    chk("pend_empty_after5", {56'd0, irq_pending}, 64'h00);
    commit_mret();
    step(1);

    // mie=0: latched, not taken despite commits
    int_mstatus_mie = 1'b0;
    irq = 8'h02; step(1); irq = '0;
    commit_valid = 1'b1; mret_commit = 1'b0; commit_next_pc = 32'h2FC;
    step(20);
    commit_valid = 1'b0;
    chk("pend1_held_mie0", {56'd0, irq_pending}, 64'h02);
    int_mstatus_mie = 1'b1;
    step(1);
    commit_entry(4'd1, 32'h300);
    commit_mret();
    step(1);

    // mret during WAIT_BND exits without entry
    irq = 8'h01; step(1); irq = '0; step(1);
    commit_mret();
    chk("pend0_kept_on_exit", {56'd0, irq_pending}, 64'h01);
    step(2);
    commit_entry(4'd0, 32'h400);
    commit_mret();
    step(1);

    // level-held irq sets pending once
    int_mstatus_mie = 1'b0;
    irq = 8'h10; step(10);
    chk("pend4_level_once", {56'd0, irq_pending}, 64'h10);
    int_mstatus_mie = 1'b1;
    step(1);
    commit_entry(4'd4, 32'h500);
    chk("pend4_cleared", {56'd0, irq_pending}, 64'h00);
    step(3);
    chk("pend4_no_reset_level", {56'd0, irq_pending}, 64'h00);
    irq = '0; step(1); irq = 8'h10; step(1);
    chk("pend4_new_edge", {56'd0, irq_pending}, 64'h10);
    commit_valid = 1'b1; mret_commit = 1'b0; commit_next_pc = 32'h510;
    step(2);
    commit_valid = 1'b0;

    // asynchronous reset while in HANDLER
    rst_n = 1'b0;
    #1;
    chk("arst_pending", {56'd0, irq_pending}, 64'h00);
    chk("arst_redirect_pc", {32'd0, redirect_pc}, 64'd0);
    chk("arst_exit_en", {63'd0, trap_exit_en}, 64'd0);
    irq = '0;
    step(2);
    rst_n = 1'b1;
    commit_valid = 1'b1; mret_commit = 1'b0; commit_next_pc = 32'h600;
    step(5);
    commit_valid = 1'b0;
    chk("post_rst_pending", {56'd0, irq_pending}, 64'h00);

    irq = 8'h80; step(1); irq = '0; step(1);
    commit_entry(4'd7, 32'h700);
    commit_mret();
    step(3);

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
